// File: rtl/pll_lock_supervisor_if.sv
// Status/control bundle between the PLL lock supervisor and its surroundings.
// The master side drives the lock indication and clear strobe; the slave side reports status.
interface pll_lock_supervisor_if;
   logic       locked;
   logic       clr_lost;
   logic       pll_rst;
   logic       core_reset;
   logic       ready;
   logic       lock_lost;
   logic [7:0] relock_count;
   logic [1:0] state;

   modport master (
      output locked, clr_lost,
      input  pll_rst, core_reset, ready, lock_lost, relock_count, state
   );

   modport slave (
      input  locked, clr_lost,
      output pll_rst, core_reset, ready, lock_lost, relock_count, state
   );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a stable lock, then releases the core reset;
// re-resets the PLL on lock timeout or on loss of lock while running.
module pll_lock_supervisor #(
   parameter int unsigned STABLE_CYCLES  = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned CNT_W          = 20
) (
   input logic            refclk,
   input logic            rst,
   pll_lock_supervisor_if.slave bus
);

   localparam int unsigned RC_W = 8;
   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RC_W-1:0]  RC_MAX      = {RC_W{1'b1}};

   typedef enum logic [1:0] {
      PLL_RESET = 2'd0,
      WAIT_LOCK = 2'd1,
      STABILIZE = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t            st;
   logic [CNT_W-1:0]  cnt;
   logic              sync1;
   logic              locked_s;
   logic              lost;
   logic [RC_W-1:0]   relocks;

   // Lock synchronizer, shared counter, state sequencing and sticky status.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         st       <= PLL_RESET;
         cnt      <= '0;
         sync1    <= 1'b0;
         locked_s <= 1'b0;
         lost     <= 1'b0;
         relocks  <= '0;
      end else begin
         sync1    <= bus.locked;
         locked_s <= sync1;
         if (bus.clr_lost) lost <= 1'b0;

         unique case (st)
            PLL_RESET: begin
               if (cnt == RST_LAST) begin
                  st  <= WAIT_LOCK;
                  cnt <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            WAIT_LOCK: begin
               // Lock wins over a coincident timeout.
               if (locked_s) begin
                  st  <= STABILIZE;
                  cnt <= '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  st  <= PLL_RESET;
                  cnt <= '0;
                  if (relocks != RC_MAX) relocks <= relocks + RC_W'(1);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            STABILIZE: begin
               if (!locked_s) begin
                  st  <= WAIT_LOCK;
                  cnt <= '0;
               end else if (cnt == STABLE_LAST) begin
                  st  <= RUN;
                  cnt <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RUN: begin
               // Set of lock_lost overrides a same-cycle clear.
               if (!locked_s) begin
                  st   <= PLL_RESET;
                  cnt  <= '0;
                  lost <= 1'b1;
                  if (relocks != RC_MAX) relocks <= relocks + RC_W'(1);
               end
            end
            default: begin
               st  <= PLL_RESET;
               cnt <= '0;
            end
         endcase
      end
   end

   // Resets are decoded straight from the state register so async reset acts at once.
   assign bus.pll_rst      = (st == PLL_RESET);
   assign bus.core_reset   = (st != RUN);
   assign bus.ready        = (st == RUN);
   assign bus.lock_lost    = lost;
   assign bus.relock_count = relocks;
   assign bus.state        = st;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomized scoreboard bench for pll_lock_supervisor with a per-edge reference model.
module tb_pll_lock_supervisor;

   localparam int unsigned STABLE  = 8;
   localparam int unsigned TIMEOUT = 32;
   localparam int unsigned PRST    = 4;

   typedef enum int {M_PRST, M_WAIT, M_STAB, M_RUN} mphase_t;

   typedef struct packed {
      logic [1:0] st;
      logic       prst;
      logic       crst;
      logic       rdy;
      logic       lost;
      logic [7:0] rc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pll_lock_supervisor_if bus_if ();

   pll_lock_supervisor #(
      .STABLE_CYCLES (STABLE),
      .TIMEOUT_CYCLES(TIMEOUT),
      .PLL_RST_CYCLES(PRST),
      .CNT_W         (20)
   ) dut (
      .refclk(clk),
      .rst   (rst),
      .bus   (bus_if)
   );

   int      vectors     = 0;
   int      miscompares = 0;
   exp_t    q[$];

   // Reference model: phase name, edge index of phase entry, lock history seen by the FSM.
   mphase_t ph;
   int      cyc;
   int      t_enter;
   bit      hist[$];
   bit      m_lost;
   int      m_rc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int in_phase();
      return cyc - t_enter + 1;
   endfunction

   task automatic model_reset();
      ph      = M_PRST;
      cyc     = 0;
      t_enter = 1;
      hist    = '{1'b0, 1'b0};
      m_lost  = 1'b0;
      m_rc    = 0;
   endtask

   task automatic enter(input mphase_t p);
      ph      = p;
      t_enter = cyc + 1;
   endtask

   task automatic bump_relock();
      if (m_rc < 255) m_rc++;
   endtask

   // One rising edge: the FSM sees the lock level applied two edges earlier.
   task automatic model_step(input bit l, input bit c);
      bit ls;
      cyc++;
      ls = hist.pop_front();
      hist.push_back(l);
      if (c) m_lost = 1'b0;
      case (ph)
         M_PRST: if (in_phase() == PRST) enter(M_WAIT);
         M_WAIT: begin
            if (ls) enter(M_STAB);
            else if (in_phase() == TIMEOUT) begin
               enter(M_PRST);
               bump_relock();
            end
         end
         M_STAB: begin
            if (!ls) enter(M_WAIT);
            else if (in_phase() == STABLE) enter(M_RUN);
         end
         M_RUN: begin
            if (!ls) begin
               enter(M_PRST);
               m_lost = 1'b1;
               bump_relock();
            end
         end
         default: ;
      endcase
   endtask

   function automatic exp_t expect_now();
      exp_t e;
      case (ph)
         M_PRST:  e.st = 2'd0;
         M_WAIT:  e.st = 2'd1;
         M_STAB:  e.st = 2'd2;
         default: e.st = 2'd3;
      endcase
      e.prst = (ph == M_PRST);
      e.crst = (ph != M_RUN);
      e.rdy  = (ph == M_RUN);
      e.lost = m_lost;
      e.rc   = 8'(m_rc);
      return e;
   endfunction

   task automatic step(input bit l, input bit c);
      bus_if.locked   = l;
      bus_if.clr_lost = c;
      model_step(l, c);
      q.push_back(expect_now());
   endtask

   task automatic cycle(input bit l, input bit c);
      @(negedge clk);
      step(l, c);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"},      32'(bus_if.state),        0);
      chk({tag, "_pll_rst"},    32'(bus_if.pll_rst),      1);
      chk({tag, "_core_reset"}, 32'(bus_if.core_reset),   1);
      chk({tag, "_ready"},      32'(bus_if.ready),        0);
      chk({tag, "_lock_lost"},  32'(bus_if.lock_lost),    0);
      chk({tag, "_relock"},     32'(bus_if.relock_count), 0);
   endtask

   task automatic drive_to_run();
      for (int i = 0; i < 200 && ph != M_RUN; i++) cycle(1'b1, 1'b0);
      if (ph != M_RUN) begin
         vectors++;
         miscompares++;
         $display("FAIL reach_run: model phase %0d expected %0d", ph, M_RUN);
      end
   endtask

   // Monitor: outputs are valid every edge; compare well after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("state",        32'(bus_if.state),        32'(e.st));
            chk("pll_rst",      32'(bus_if.pll_rst),      32'(e.prst));
            chk("core_reset",   32'(bus_if.core_reset),   32'(e.crst));
            chk("ready",        32'(bus_if.ready),        32'(e.rdy));
            chk("lock_lost",    32'(bus_if.lock_lost),    32'(e.lost));
            chk("relock_count", 32'(bus_if.relock_count), 32'(e.rc));
         end
      end
   end

   initial begin
      int len;
      bit lv;
      rst             = 1'b1;
      bus_if.locked   = 1'b0;
      bus_if.clr_lost = 1'b0;
      model_reset();
      #1;
      chk_reset_vals("por");
      repeat (2) @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 1'b0);

      // No lock: periodic timeouts.
      repeat (79) cycle(1'b0, 1'b0);

      // Lock arrives and is held through stabilize into run.
      repeat (30) cycle(1'b1, 1'b0);

      // Loss of lock in run, then a glitch during stabilize.
      repeat (3) cycle(1'b0, 1'b0);
      for (int i = 0; i < 100 && !(ph == M_STAB && in_phase() == 5); i++) cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      repeat (25) cycle(1'b1, 1'b0);

      // clr_lost coincident with a run loss, then an isolated clear.
      drive_to_run();
      for (int i = 0; i < 6; i++) cycle(1'b0, (ph == M_RUN) && (hist[0] == 1'b0));
      repeat (3) cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);
      repeat (3) cycle(1'b0, 1'b0);

      // Random lock episodes with occasional clears.
      repeat (60) begin
         lv  = 1'($urandom_range(0, 1));
         len = (($urandom_range(0, 3)) == 0) ? 1 : int'($urandom_range(1, 50));
         repeat (len) cycle(lv, $urandom_range(0, 9) == 0);
      end

      // Asynchronous reset between edges while running with status set.
      repeat (3) cycle(1'b0, 1'b0);
      drive_to_run();
      repeat (2) cycle(1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_reset_vals("async_rst");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 1'b0);

      // Long no-lock run to saturate the relock counter.
      repeat (260 * (PRST + TIMEOUT)) cycle(1'b0, 1'b0);
      repeat (3) cycle(1'b0, 1'b0);

      @(posedge clk);
      #3;
      chk("queue_drained", 32'(q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 Parameter: STABLE_CYCLES, default 1000, consecutive synchronized-lock cycles required before core reset release.
REQ-002 Parameter: TIMEOUT_CYCLES, default 1000000, maximum WAIT_LOCK cycles before a PLL re-reset.
REQ-003 Parameter: PLL_RST_CYCLES, default 16, width of each pll_rst pulse in cycles.
REQ-004 Parameter: CNT_W, default 20, width of the shared cycle counter; must satisfy 2^CNT_W > max(STABLE_CYCLES, TIMEOUT_CYCLES, PLL_RST_CYCLES).
REQ-005 Port: refclk  in  1  sole clock; the 50 MHz board reference feeding the PLL.
REQ-006 Port: rst  in  1  reset; asynchronous, active-high.
REQ-007 Port: locked  in  1  PLL lock indication; asynchronous to refclk.
REQ-008 Port: clr_lost  in  1  single-cycle clear of lock_lost.
REQ-009 Port: pll_rst  out  1  reset to the PLL rst input.
REQ-010 Port: core_reset  out  1  active-high reset for logic clocked by PLL outputs.
REQ-011 Port: ready  out  1  inverse of core_reset.
REQ-012 Port: lock_lost  out  1  sticky flag set on loss of lock while running.
REQ-013 Port: relock_count  out  8  saturating count of PLL re-resets.
REQ-014 Port: state  out  2  current FSM encoding, for debug.

Function
REQ-015 locked SHALL pass through a 2-flop synchronizer; locked_s is the second flop; the FSM SHALL use only locked_s.
REQ-016 FSM states and encodings: PLL_RESET=0, WAIT_LOCK=1, STABILIZE=2, RUN=3.
REQ-017 PLL_RESET: pll_rst=1; the counter counts from 0; at count PLL_RST_CYCLES-1 go to WAIT_LOCK and clear the counter, so pll_rst stays high exactly PLL_RST_CYCLES cycles.
REQ-018 WAIT_LOCK: locked_s=1 goes to STABILIZE with the counter cleared.
REQ-019 WAIT_LOCK: otherwise the counter increments; at count TIMEOUT_CYCLES-1 go to PLL_RESET and increment relock_count.
REQ-020 STABILIZE: locked_s=0 goes to WAIT_LOCK with the counter cleared and the timeout restarted.
REQ-021 STABILIZE: otherwise the counter increments; at count STABLE_CYCLES-1 go to RUN, giving exactly STABLE_CYCLES cycles in STABILIZE.
REQ-022 RUN: locked_s=0 goes to PLL_RESET, sets lock_lost, increments relock_count and clears the counter.
REQ-023 core_reset SHALL be 0 iff state==RUN, decoded directly from the state register with no extra stage.
REQ-024 pll_rst SHALL be 1 iff state==PLL_RESET, decoded directly from the state register.
REQ-025 relock_count SHALL saturate at 255 and never wrap.
REQ-026 lock_lost SHALL clear on clr_lost=1; if set and clear occur in the same cycle, set wins.
REQ-027 The counter SHALL clear on every state transition and SHALL never wrap within a state.
REQ-028 A locked_s change in the same cycle as a counter terminal count SHALL take the locked_s-driven transition (REQ-018, REQ-020, REQ-022).

Reset
REQ-029 rst=1 SHALL immediately, without a clock edge, force: state=PLL_RESET, counter=0, both sync flops=0, lock_lost=0, relock_count=0, pll_rst=1, core_reset=1, ready=0.
REQ-030 After rst deasserts, the first PLL_RESET pulse SHALL still last PLL_RST_CYCLES cycles.
REQ-031 rst asserted mid-operation SHALL override all other behaviour, including in RUN.

Verification (STABLE_CYCLES=8, TIMEOUT_CYCLES=32, PLL_RST_CYCLES=4)
REQ-032 locked held 0 after reset release -> pll_rst high 4 cycles, low 32 cycles, high again; relock_count=1; repeats; relock_count saturates at 255 after 255 timeouts.
REQ-033 locked rises 10 cycles into WAIT_LOCK -> STABILIZE at the 2nd edge after first sampling; core_reset falls and ready rises 10 edges after that first sampling edge; relock_count=0.
REQ-034 In STABILIZE, locked drops for 1 cycle after 5 stable cycles -> WAIT_LOCK; core_reset stays 1; after locked returns, a full 8-cycle stabilize occurs before RUN.
REQ-035 In RUN, locked falls -> within 3 edges core_reset=1 and pll_rst=1 for 4 cycles; lock_lost=1; relock_count increments by 1.
REQ-036 clr_lost pulsed in the same cycle as a RUN loss of lock -> lock_lost=1; a later isolated clr_lost pulse -> lock_lost=0 next cycle.
REQ-037 rst asserted between clock edges while in RUN -> pll_rst=1, core_reset=1, lock_lost=0, relock_count=0 before the next edge.
